// File: rtl/rtob_pkg.sv
// rtob_pkg
// Shared types and constants for the RTOB write-side arbiter.
//   rtob_state_e : command FSM states (IDLE, RUN, FLUSH)
//   TS_W, DATA_W : timestamp and event widths
//   TS_MSB/TS_LSB: timestamp field position inside an event
package rtob_pkg;

  localparam int TS_W   = 64;
  localparam int DATA_W = 128;
  localparam int TS_MSB = 127;
  localparam int TS_LSB = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rtob_state_e;

endpackage

// File: rtl/rtob_wr_arbiter_if.sv
// rtob_wr_arbiter_if
// Bundles the requester handshakes, host commands and core-facing signals
// of one RTOB write channel.
//   master : event sources / host side (drives requests, commands, rtob_full)
//   slave  : the arbiter (drives ready, core write port, status)
interface rtob_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128
);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       start_cmd;
  logic                       stop_cmd;
  logic                       flush_cmd;
  logic                       rtob_full;
  logic                       rtob_write;
  logic [DATA_W-1:0]          rtob_din;
  logic                       rtob_auto_start;
  logic                       rtob_flush;
  logic                       order_error;
  logic [$clog2(NUM_REQ)-1:0] order_err_src;
  logic [31:0]                accept_count;

  modport master (
    output req_valid, req_data, start_cmd, stop_cmd, flush_cmd, rtob_full,
    input  req_ready, rtob_write, rtob_din, rtob_auto_start, rtob_flush,
           order_error, order_err_src, accept_count
  );

  modport slave (
    input  req_valid, req_data, start_cmd, stop_cmd, flush_cmd, rtob_full,
    output req_ready, rtob_write, rtob_din, rtob_auto_start, rtob_flush,
           order_error, order_err_src, accept_count
  );

endinterface

// File: rtl/rtob_rr_arbiter.sv
// rtob_rr_arbiter
// Purely combinational round-robin picker.
//   req_i    : request vector
//   enable_i : when low, no grant is issued
//   ptr_i    : highest-priority index for this cycle
//   grant_o  : one-hot grant (or zero)
//   winner_o : index of the granted requester (0 when no grant)
module rtob_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               enable_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   winner_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan upward from ptr_i with wrap; the first set request wins.
  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    if (enable_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
        if (!found && req_i[idx]) begin
          found        = 1'b1;
          grant_o[idx] = 1'b1;
          winner_o     = idx;
        end
      end
    end
  end

endmodule

// File: rtl/rtob_wr_arbiter.sv
// rtob_wr_arbiter
// Write-side controller for one RTOB_Core channel: merges NUM_REQ event
// producers into the core write port with round-robin arbitration, drops
// events whose timestamp goes backwards, and sequences auto_start/flush.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : rtob_wr_arbiter_if.slave (requests, commands, core port, status)
module rtob_wr_arbiter
  import rtob_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128
) (
  input logic               clk,
  input logic               reset,
  rtob_wr_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  rtob_state_e         state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [TS_W-1:0]     last_ts_q;
  logic                ts_seen_q;
  logic                order_error_q;
  logic [PTR_W-1:0]    order_err_src_q;
  logic [31:0]         accept_count_q;
  logic                write_q;
  logic [DATA_W-1:0]   din_q;
  logic                auto_start_q;
  logic                flush_q;

  logic                grant_en;
  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    winner;
  logic [DATA_W-1:0]   win_data;
  logic [TS_W-1:0]     win_ts;
  logic                handshake;
  logic                out_of_order;
  logic                accept_ev;
  logic                drop_ev;
  logic [PTR_W-1:0]    next_ptr;

  // A pending flush_cmd blocks grants this cycle so nothing races the flush.
  assign grant_en = (state_q != FLUSH) && !bus.flush_cmd && !bus.rtob_full;

  rtob_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i    (bus.req_valid),
    .enable_i (grant_en),
    .ptr_i    (rr_ptr_q),
    .grant_o  (grant),
    .winner_o (winner)
  );

  assign win_data     = bus.req_data[int'(winner)*DATA_W +: DATA_W];
  assign win_ts       = win_data[TS_MSB:TS_LSB];
  assign handshake    = |(grant & bus.req_valid);
  assign out_of_order = ts_seen_q && (win_ts < last_ts_q);
  assign accept_ev    = handshake && !out_of_order;
  assign drop_ev      = handshake && out_of_order;
  assign next_ptr     = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // flush_cmd overrides everything; FLUSH always falls back to IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.flush_cmd) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE:    if (bus.start_cmd) state_d = RUN;
        RUN:     if (bus.stop_cmd)  state_d = IDLE;
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status is cleared on the edge entering FLUSH so the flush cycle already
  // shows zeroed counters; no grant can coincide with that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      last_ts_q       <= '0;
      ts_seen_q       <= 1'b0;
      order_error_q   <= 1'b0;
      order_err_src_q <= '0;
      accept_count_q  <= '0;
      write_q         <= 1'b0;
      din_q           <= '0;
      auto_start_q    <= 1'b0;
      flush_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      auto_start_q <= (state_d == RUN);
      flush_q      <= (state_d == FLUSH);
      write_q      <= accept_ev;
      if (accept_ev) begin
        din_q <= win_data;
      end
      if (handshake) begin
        rr_ptr_q <= next_ptr;
      end
      if (state_d == FLUSH) begin
        last_ts_q       <= '0;
        ts_seen_q       <= 1'b0;
        order_error_q   <= 1'b0;
        order_err_src_q <= '0;
        accept_count_q  <= '0;
      end else begin
        if (accept_ev) begin
          last_ts_q <= win_ts;
          ts_seen_q <= 1'b1;
          if (accept_count_q != 32'hFFFF_FFFF) begin
            accept_count_q <= accept_count_q + 32'd1;
          end
        end
        if (drop_ev) begin
          order_error_q <= 1'b1;
          if (!order_error_q) begin
            order_err_src_q <= winner;
          end
        end
      end
    end
  end

  assign bus.req_ready       = grant;
  assign bus.rtob_write      = write_q;
  assign bus.rtob_din        = din_q;
  assign bus.rtob_auto_start = auto_start_q;
  assign bus.rtob_flush      = flush_q;
  assign bus.order_error     = order_error_q;
  assign bus.order_err_src   = order_err_src_q;
  assign bus.accept_count    = accept_count_q;

endmodule

// File: tb/tb_rtob_wr_arbiter.sv
// tb_rtob_wr_arbiter
// Directed scenarios for rtob_wr_arbiter with hand-computed expectations.
module tb_rtob_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 128;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  rtob_wr_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

  rtob_wr_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] ts, input logic [63:0] pl);
    bus.req_data[i*DW +: DW] = {ts, pl};
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.start_cmd = 1'b0;
    bus.stop_cmd  = 1'b0;
    bus.flush_cmd = 1'b0;
    bus.rtob_full = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.rtob_write !== 1'b0 || bus.rtob_din !== '0 || bus.rtob_auto_start !== 1'b0 ||
        bus.rtob_flush !== 1'b0 || bus.order_error !== 1'b0 || bus.order_err_src !== '0 ||
        bus.accept_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: write=%0b din=%0h auto=%0b flush=%0b err=%0b src=%0d cnt=%0d expected all 0",
               bus.rtob_write, bus.rtob_din, bus.rtob_auto_start, bus.rtob_flush,
               bus.order_error, bus.order_err_src, bus.accept_count);
    end
    bus.req_valid = 4'b1010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL reset_rrptr: req_ready=%b expected 0010", bus.req_ready);
    end
    clear_inputs();
  endtask

  task automatic test_single_in_order();
    logic [127:0] exp;
    do_reset();
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 64'(10 * (i + 1)), 64'hA000 + 64'(i));
      exp = {64'(10 * (i + 1)), 64'hA000 + 64'(i)};
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
        failures++;
        $display("[TB] FAIL single_ready%0d: req_ready=%b expected 0001", i, bus.req_ready);
      end
      tick();
      checks++;
      if (bus.rtob_write !== 1'b1 || bus.rtob_din !== exp) begin
        failures++;
        $display("[TB] FAIL single_write%0d: write=%0b din=%h expected write=1 din=%h",
                 i, bus.rtob_write, bus.rtob_din, exp);
      end
    end
    bus.req_valid = '0;
    tick();
    checks++;
    if (bus.rtob_write !== 1'b0 || bus.rtob_din !== exp || bus.accept_count !== 32'd3 ||
        bus.rtob_auto_start !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_idle: write=%0b din=%h cnt=%0d auto=%0b expected write=0 din=%h cnt=3 auto=0",
               bus.rtob_write, bus.rtob_din, bus.accept_count, bus.rtob_auto_start, exp);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_grant [5];
    exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 64'd100, 64'(i));
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== exp_grant[c]) begin
        failures++;
        $display("[TB] FAIL rr_grant%0d: req_ready=%b expected %b", c, bus.req_ready, exp_grant[c]);
      end
      tick();
    end
    bus.req_valid = '0;
    checks++;
    if (bus.order_error !== 1'b0 || bus.accept_count !== 32'd5 || bus.rtob_din !== {64'd100, 64'd0}) begin
      failures++;
      $display("[TB] FAIL rr_status: err=%0b cnt=%0d din=%h expected err=0 cnt=5 din=%h",
               bus.order_error, bus.accept_count, bus.rtob_din, {64'd100, 64'd0});
    end
    clear_inputs();
  endtask

  task automatic test_order_error();
    do_reset();
    set_req(1, 64'd50, 64'h11);
    bus.req_valid = 4'b0010;
    tick();
    checks++;
    if (bus.rtob_write !== 1'b1) begin
      failures++;
      $display("[TB] FAIL order_first_write: write=%0b expected 1", bus.rtob_write);
    end
    set_req(2, 64'd40, 64'h22);
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL order_consume: req_ready=%b expected 0100", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rtob_write !== 1'b0 || bus.order_error !== 1'b1 || bus.order_err_src !== 2'd2 ||
        bus.accept_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL order_drop: write=%0b err=%0b src=%0d cnt=%0d expected write=0 err=1 src=2 cnt=1",
               bus.rtob_write, bus.order_error, bus.order_err_src, bus.accept_count);
    end
    // Equal timestamp is legal; a later drop from req3 must not move the source.
    set_req(3, 64'd50, 64'h33);
    bus.req_valid = 4'b1000;
    tick();
    checks++;
    if (bus.rtob_write !== 1'b1 || bus.rtob_din !== {64'd50, 64'h33}) begin
      failures++;
      $display("[TB] FAIL order_equal_ts: write=%0b din=%h expected write=1 din=%h",
               bus.rtob_write, bus.rtob_din, {64'd50, 64'h33});
    end
    set_req(3, 64'd10, 64'h34);
    tick();
    checks++;
    if (bus.rtob_write !== 1'b0 || bus.order_err_src !== 2'd2 || bus.accept_count !== 32'd2) begin
      failures++;
      $display("[TB] FAIL order_sticky_src: write=%0b src=%0d cnt=%0d expected write=0 src=2 cnt=2",
               bus.rtob_write, bus.order_err_src, bus.accept_count);
    end
    clear_inputs();
  endtask

  task automatic test_full_backpressure();
    do_reset();
    set_req(0, 64'd5, 64'h55);
    bus.req_valid = 4'b0001;
    bus.rtob_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL full_ready%0d: req_ready=%b expected 0000", c, bus.req_ready);
      end
      tick();
      checks++;
      if (bus.rtob_write !== 1'b0) begin
        failures++;
        $display("[TB] FAIL full_write%0d: write=%0b expected 0", c, bus.rtob_write);
      end
    end
    bus.rtob_full = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL full_release_ready: req_ready=%b expected 0001", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rtob_write !== 1'b1 || bus.rtob_din !== {64'd5, 64'h55}) begin
      failures++;
      $display("[TB] FAIL full_resume: write=%0b din=%h expected write=1 din=%h",
               bus.rtob_write, bus.rtob_din, {64'd5, 64'h55});
    end
    clear_inputs();
  endtask

  task automatic test_start_flush();
    do_reset();
    bus.start_cmd = 1'b1;
    tick();
    bus.start_cmd = 1'b0;
    checks++;
    if (bus.rtob_auto_start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL start_auto: auto_start=%0b expected 1", bus.rtob_auto_start);
    end
    set_req(0, 64'd30, 64'h1);
    bus.req_valid = 4'b0001;
    tick();
    set_req(1, 64'd20, 64'h2);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    checks++;
    if (bus.accept_count !== 32'd1 || bus.order_error !== 1'b1 || bus.order_err_src !== 2'd1) begin
      failures++;
      $display("[TB] FAIL preflush_status: cnt=%0d err=%0b src=%0d expected cnt=1 err=1 src=1",
               bus.accept_count, bus.order_error, bus.order_err_src);
    end
    set_req(3, 64'd5, 64'h3);
    bus.req_valid = 4'b1000;
    bus.flush_cmd = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL flush_no_grant_n: req_ready=%b expected 0000", bus.req_ready);
    end
    tick();
    bus.flush_cmd = 1'b0;
    #1;
    checks++;
    if (bus.rtob_flush !== 1'b1 || bus.rtob_write !== 1'b0 || bus.accept_count !== 32'd0 ||
        bus.order_error !== 1'b0 || bus.order_err_src !== 2'd0 || bus.req_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL flush_cycle: flush=%0b write=%0b cnt=%0d err=%0b src=%0d ready=%b expected 1 0 0 0 0 0000",
               bus.rtob_flush, bus.rtob_write, bus.accept_count, bus.order_error,
               bus.order_err_src, bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rtob_flush !== 1'b0 || bus.rtob_auto_start !== 1'b0 || bus.req_ready !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL flush_resume: flush=%0b auto=%0b ready=%b expected flush=0 auto=0 ready=1000",
               bus.rtob_flush, bus.rtob_auto_start, bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    checks++;
    if (bus.rtob_write !== 1'b1 || bus.rtob_din !== {64'd5, 64'h3} || bus.order_error !== 1'b0 ||
        bus.accept_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL flush_post_write: write=%0b din=%h err=%0b cnt=%0d expected write=1 din=%h err=0 cnt=1",
               bus.rtob_write, bus.rtob_din, bus.order_error, bus.accept_count, {64'd5, 64'h3});
    end
    clear_inputs();
  endtask

  task automatic test_reset_midop();
    do_reset();
    bus.start_cmd = 1'b1;
    tick();
    bus.start_cmd = 1'b0;
    set_req(0, 64'd7, 64'h77);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    checks++;
    if (bus.rtob_write !== 1'b1 || bus.rtob_auto_start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midop_prewrite: write=%0b auto=%0b expected write=1 auto=1",
               bus.rtob_write, bus.rtob_auto_start);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.rtob_write !== 1'b0 || bus.rtob_din !== '0 || bus.rtob_auto_start !== 1'b0 ||
        bus.rtob_flush !== 1'b0 || bus.accept_count !== 32'd0 || bus.order_error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midop_reset: write=%0b din=%h auto=%0b flush=%0b cnt=%0d err=%0b expected all 0",
               bus.rtob_write, bus.rtob_din, bus.rtob_auto_start, bus.rtob_flush,
               bus.accept_count, bus.order_error);
    end
    // Reset coinciding with a handshake drops the in-flight write.
    bus.req_valid = 4'b0001;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid = '0;
    checks++;
    if (bus.rtob_write !== 1'b0 || bus.accept_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL midop_inflight: write=%0b cnt=%0d expected write=0 cnt=0",
               bus.rtob_write, bus.accept_count);
    end
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear_inputs();
    tick();
    test_reset();
    test_single_in_order();
    test_round_robin();
    test_order_error();
    test_full_backpressure();
    test_start_flush();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
